// File: rtl/score_display_driver.sv
// score_display_driver: BCD score/high score keeper driving a 4-digit multiplexed 7-segment display.
module score_display_driver #(
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        CLK_50M,
  input  logic        RST,
  input  logic        add_cube,
  input  logic        restart,
  input  logic        show_high,
  output logic [6:0]  seg_out,
  output logic [3:0]  sel,
  output logic [15:0] score,
  output logic [15:0] high_score
);
  logic        add_cube_d;
  logic        inc;
  logic        carry;
  logic        tc;
  logic        blank;
  logic [15:0] score_inc;
  logic [15:0] cnt;
  logic [15:0] src;
  logic [1:0]  idx;
  logic [3:0]  digit;
  logic [6:0]  glyph;
  logic [6:0]  seg_nx;
  logic [3:0]  sel_nx;
  assign inc = add_cube & ~add_cube_d;
  always_comb begin
    score_inc = score;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      score_inc[4*i +: 4] = carry ? (score[4*i +: 4] == 4'd9 ? 4'd0 : score[4*i +: 4] + 4'd1) : score[4*i +: 4];
      carry = carry & (score[4*i +: 4] == 4'd9);
    end
  end
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      add_cube_d <= 1'b0;
      score      <= '0;
      high_score <= '0;
    end else begin
      add_cube_d <= add_cube;
      if (restart)
        score <= '0;
      else if (inc && score != 16'h9999)
        score <= score_inc;
      if (score > high_score)
        high_score <= score;
    end
  end
  assign tc = cnt == 16'(SCAN_DIV - 1);
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= tc ? '0 : cnt + 16'd1;
      idx <= idx + 2'(tc);
    end
  end
  assign src   = show_high ? high_score : score;
  assign digit = src[{idx, 2'b00} +: 4];
  assign blank = (idx == 2'd3 && src[15:12] == '0) ||
                 (idx == 2'd2 && src[15:8] == '0) ||
                 (idx == 2'd1 && src[15:4] == '0);
  always_comb begin
    case (digit)
      4'd0:    glyph = 7'b0111111;
      4'd1:    glyph = 7'b0000110;
      4'd2:    glyph = 7'b1011011;
      4'd3:    glyph = 7'b1001111;
      4'd4:    glyph = 7'b1100110;
      4'd5:    glyph = 7'b1101101;
      4'd6:    glyph = 7'b1111101;
      4'd7:    glyph = 7'b0000111;
      4'd8:    glyph = 7'b1111111;
      4'd9:    glyph = 7'b1101111;
      default: glyph = 7'b0000000;
    endcase
  end
  assign seg_nx = blank ? 7'b0000000 : glyph;
  assign sel_nx = 4'b0001 << idx;
  // Registering both from the same idx keeps segments and select aligned.
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      seg_out <= SEG_ACTIVE_LOW ? 7'b1000000 : 7'b0111111;
      sel     <= SEG_ACTIVE_LOW ? 4'b1110 : 4'b0001;
    end else begin
      seg_out <= SEG_ACTIVE_LOW ? ~seg_nx : seg_nx;
      sel     <= SEG_ACTIVE_LOW ? ~sel_nx : sel_nx;
    end
  end
endmodule
